// File: rtl/router_reg_param.sv
// -----------------------------------------------------------------------------
// router_reg_param
// Parametrised router register stage between the router FSM and the output
// FIFOs. It latches and validates the header, steers header / payload / held
// word onto dout under the FSM state strobes, holds one word while the FIFO is
// full, and accumulates an integrity check over header and payload. The
// result is reported as a two-bit error code.
//
// Optional feature macro: CRC_CHECK_EN
//   defined   : int_chk is a DATA_WIDTH-bit CRC (poly CRC_POLY, init 0,
//               MSB-first, one word per fold cycle)
//   undefined : int_chk is a plain XOR fold, CRC_POLY has no effect
//
// Ports:
//   clk              rising-edge clock
//   resetn           synchronous active-low reset
//   packet_valid     source data valid (low during the check word)
//   datain           header / payload / check word
//   fifo_full        selected output FIFO is full
//   detect_add       FSM DECODE_ADDRESS
//   lfd_state        FSM LOAD_FIRST_DATA
//   ld_state         FSM LOAD_DATA
//   laf_state        FSM LOAD_AFTER_FULL
//   full_state       FSM FIFO_FULL_STATE
//   rst_int_reg      clears low_packet_valid
//   dout             word to the FIFO
//   parity_done      check word received and accumulated
//   low_packet_valid packet_valid dropped while in LOAD_DATA
//   err              OR of err_code
//   err_code         bit0 check mismatch, bit1 length mismatch
// -----------------------------------------------------------------------------
module router_reg_param #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 2,
    parameter int                    NUM_CH     = 3,
    parameter logic [DATA_WIDTH-1:0] CRC_POLY   = DATA_WIDTH'(8'h07)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  packet_valid,
    input  logic [DATA_WIDTH-1:0] datain,
    input  logic                  fifo_full,
    input  logic                  detect_add,
    input  logic                  lfd_state,
    input  logic                  ld_state,
    input  logic                  laf_state,
    input  logic                  full_state,
    input  logic                  rst_int_reg,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  parity_done,
    output logic                  low_packet_valid,
    output logic                  err,
    output logic [1:0]            err_code
);

    localparam int LEN_WIDTH = DATA_WIDTH - ADDR_WIDTH;

`ifdef CRC_CHECK_EN
    localparam bit USE_CRC = 1'b1;
`else
    localparam bit USE_CRC = 1'b0;
`endif

    logic [DATA_WIDTH-1:0] hdr_reg, hdr_next;
    logic [DATA_WIDTH-1:0] hold_reg, hold_next;
    logic [DATA_WIDTH-1:0] dout_reg, dout_next;
    logic [DATA_WIDTH-1:0] int_chk_reg, int_chk_next;
    logic [DATA_WIDTH-1:0] pkt_chk_reg, pkt_chk_next;
    logic [LEN_WIDTH-1:0]  pay_cnt_reg, pay_cnt_next;
    logic                  low_pv_reg, low_pv_next;
    logic                  parity_done_reg, parity_done_next;
    logic                  err_reg, err_next;
    logic [1:0]            err_code_reg, err_code_next;

    logic                  addr_ok;
    logic                  hdr_fold;
    logic                  pay_fold;
    logic [DATA_WIDTH-1:0] fold_word;
    logic [DATA_WIDTH-1:0] fold_result;
    logic [LEN_WIDTH-1:0]  len_field;

    // One extra bit so NUM_CH == 2**ADDR_WIDTH does not overflow the compare.
    assign addr_ok   = ({1'b0, datain[ADDR_WIDTH-1:0]} < (ADDR_WIDTH+1)'(NUM_CH));
    assign len_field = hdr_reg[DATA_WIDTH-1:ADDR_WIDTH];

    // Header fold takes precedence so a word is never folded twice.
    assign hdr_fold  = lfd_state;
    assign pay_fold  = !lfd_state && ld_state && packet_valid && !full_state;
    assign fold_word = lfd_state ? hdr_reg : datain;

    // CRC unrolled one shift per stage. Because the CRC register and the data
    // word have the same width, XOR-ing the word in first and then shifting
    // DATA_WIDTH times equals feeding the word bit-serially MSB first.
    logic [DATA_WIDTH-1:0] crc_stage [DATA_WIDTH+1];
    assign crc_stage[0] = int_chk_reg ^ fold_word;

    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_crc
            assign crc_stage[gi+1] = crc_stage[gi][DATA_WIDTH-1]
                                   ? ((crc_stage[gi] << 1) ^ CRC_POLY)
                                   : (crc_stage[gi] << 1);
        end
    endgenerate

    assign fold_result = USE_CRC ? crc_stage[DATA_WIDTH] : crc_stage[0];

    always_comb begin
        hdr_next         = hdr_reg;
        hold_next        = hold_reg;
        dout_next        = dout_reg;
        int_chk_next     = int_chk_reg;
        pkt_chk_next     = pkt_chk_reg;
        pay_cnt_next     = pay_cnt_reg;
        low_pv_next      = low_pv_reg;
        parity_done_next = parity_done_reg;
        err_code_next    = err_code_reg;

        // Headers addressing a non-existent channel are dropped.
        if (detect_add && packet_valid && addr_ok)
            hdr_next = datain;

        if (lfd_state)
            dout_next = hdr_reg;
        else if (ld_state && !fifo_full)
            dout_next = datain;
        else if (ld_state && fifo_full)
            hold_next = datain;
        else if (laf_state)
            dout_next = hold_reg;

        if (detect_add)
            int_chk_next = '0;
        else if (hdr_fold || pay_fold)
            int_chk_next = fold_result;

        if (detect_add)
            pay_cnt_next = '0;
        else if (pay_fold && (pay_cnt_reg != {LEN_WIDTH{1'b1}}))
            pay_cnt_next = pay_cnt_reg + 1'b1;

        if (ld_state && !packet_valid)
            pkt_chk_next = datain;

        if (rst_int_reg)
            low_pv_next = 1'b0;
        else if (ld_state && !packet_valid)
            low_pv_next = 1'b1;

        // The laf term covers a check word that arrived while the FIFO was full.
        if (detect_add)
            parity_done_next = 1'b0;
        else if ((ld_state && !fifo_full && !packet_valid) ||
                 (laf_state && low_pv_reg && !parity_done_reg))
            parity_done_next = 1'b1;

        if (detect_add)
            err_code_next = 2'b00;
        else if (parity_done_reg)
            err_code_next = {(pay_cnt_reg != len_field), (int_chk_reg != pkt_chk_reg)};

        err_next = |err_code_next;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            hdr_reg         <= '0;
            hold_reg        <= '0;
            dout_reg        <= '0;
            int_chk_reg     <= '0;
            pkt_chk_reg     <= '0;
            pay_cnt_reg     <= '0;
            low_pv_reg      <= 1'b0;
            parity_done_reg <= 1'b0;
            err_reg         <= 1'b0;
            err_code_reg    <= 2'b00;
        end else begin
            hdr_reg         <= hdr_next;
            hold_reg        <= hold_next;
            dout_reg        <= dout_next;
            int_chk_reg     <= int_chk_next;
            pkt_chk_reg     <= pkt_chk_next;
            pay_cnt_reg     <= pay_cnt_next;
            low_pv_reg      <= low_pv_next;
            parity_done_reg <= parity_done_next;
            err_reg         <= err_next;
            err_code_reg    <= err_code_next;
        end
    end

    assign dout             = dout_reg;
    assign parity_done      = parity_done_reg;
    assign low_packet_valid = low_pv_reg;
    assign err              = err_reg;
    assign err_code         = err_code_reg;

endmodule
